// File: rtl/adda_stream_ctrl.sv
// -----------------------------------------------------------------------------
// adda_stream_ctrl
//   ADC->DAC streaming path for the ULX3S AD/DA add-on. Generates the ADC and
//   DAC sample clocks from the system clock. Captures one ADC sample per sample
//   period into a circular delay buffer. Drives the DAC bus in one of four modes:
//   delay/pass, ramp test, hold or midscale.
//
//   Ports:
//     i_clk            system clock
//     i_rst_n          asynchronous active-low reset (synchronous release)
//     i_enable         1 = run sample clocks and stream, 0 = idle
//     i_mode           00 delay/pass, 01 ramp, 10 hold, 11 midscale
//     i_delay          delay in samples (0 = bypass the buffer)
//     i_ad_data        ADC parallel data (offset binary)
//     o_adclk          ADC sample clock
//     o_daclk          DAC sample clock (inverse of o_adclk while enabled)
//     o_da_data        DAC parallel data, registered
//     o_sample_strobe  one-cycle pulse in every cycle that follows an update
//                      (the cycle in which o_da_data shows its new value)
// -----------------------------------------------------------------------------
module adda_stream_ctrl #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic [1:0]        i_mode,
    input  logic [ADDR_W-1:0] i_delay,
    input  logic [DATA_W-1:0] i_ad_data,
    output logic              o_adclk,
    output logic              o_daclk,
    output logic [DATA_W-1:0] o_da_data,
    output logic              o_sample_strobe
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [DATA_W-1:0] MID      = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLK_DIV / 2);
    localparam logic [ADDR_W:0]   FILL_MAX = (ADDR_W+1)'(DEPTH);

    localparam logic [1:0] MODE_DELAY = 2'b00;
    localparam logic [1:0] MODE_RAMP  = 2'b01;
    localparam logic [1:0] MODE_HOLD  = 2'b10;
    localparam logic [1:0] MODE_MID   = 2'b11;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              tick;
    logic              upd;
    logic [DATA_W-1:0] ad_q;
    logic [DATA_W-1:0] ramp;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W:0]   fill;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] sel;
    logic              adclk_next;

    // Delay buffer; not reset. The fill count keeps unwritten slots from
    // ever reaching the output.
    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        cnt_next = '0;
        if (i_enable) begin
            cnt_next = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick       = i_enable && (cnt == CNT_LAST);
    // Clocks are registered from the next count so o_daclk is an exact
    // inverse of o_adclk rather than lagging it by one cycle.
    assign adclk_next = i_enable && (cnt_next < CNT_HALF);

    // Read happens in the same cycle as the write to mem[wptr], so it sees
    // pre-write contents; the largest delay (DEPTH-1) never hits wptr.
    assign rd_addr = wptr - i_delay;

    always_comb begin
        sel = o_da_data;
        case (i_mode)
            MODE_DELAY: begin
                if (i_delay == '0) begin
                    sel = ad_q;
                end else if ({1'b0, i_delay} <= fill) begin
                    sel = mem[rd_addr];
                end else begin
                    sel = MID;
                end
            end
            MODE_RAMP: sel = ramp;
            MODE_HOLD: sel = o_da_data;
            MODE_MID:  sel = MID;
            default:   sel = o_da_data;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt             <= '0;
            o_adclk         <= 1'b0;
            o_daclk         <= 1'b0;
            o_sample_strobe <= 1'b0;
            o_da_data       <= MID;
            ramp            <= '0;
            wptr            <= '0;
            fill            <= '0;
            ad_q            <= MID;
            upd             <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            o_adclk <= adclk_next;
            o_daclk <= i_enable && !adclk_next;
            // upd is not gated by i_enable: a pending update still completes
            // after enable drops.
            upd     <= tick;
            if (tick) begin
                ad_q <= i_ad_data;
            end
            o_sample_strobe <= upd;
            if (upd) begin
                wptr      <= wptr + 1'b1;
                fill      <= (fill == FILL_MAX) ? fill : fill + 1'b1;
                o_da_data <= sel;
                if (i_mode == MODE_RAMP) begin
                    ramp <= ramp + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (upd) begin
            mem[wptr] <= ad_q;
        end
    end

endmodule
